// File: rtl/tone_generator.sv
// Square-wave tone source for the piano: filters the selector's note code
// and toggles oAudio at the half-period of the accepted note.
module tone_generator #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic [7:0] iNote,
    output logic       oAudio,
    output logic       oPlaying,
    output logic [7:0] oNote
);

    localparam int MAX_HALF = 2 * (CLK_HZ / 524);
    localparam int PW = $clog2(MAX_HALF + 1);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

    localparam logic [PW-1:0] HALF_C = PW'(CLK_HZ / 524);
    localparam logic [PW-1:0] HALF_D = PW'(CLK_HZ / 588);
    localparam logic [PW-1:0] HALF_E = PW'(CLK_HZ / 660);
    localparam logic [PW-1:0] HALF_F = PW'(CLK_HZ / 698);
    localparam logic [PW-1:0] HALF_G = PW'(CLK_HZ / 784);
    localparam logic [PW-1:0] HALF_A = PW'(CLK_HZ / 880);
    localparam logic [PW-1:0] HALF_B = PW'(CLK_HZ / 988);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    function automatic logic isValid(input logic [7:0] code);
        return (code[7:6] == 2'd0) && (code[5:4] != 2'd3) &&
               (code[3:0] >= 4'd1) && (code[3:0] <= 4'd7);
    endfunction

    function automatic logic [PW-1:0] halfOf(input logic [5:0] code);
        logic [PW-1:0] mid;
        logic [PW-1:0] h;
        case (code[3:0])
            4'd1:    mid = HALF_C;
            4'd2:    mid = HALF_D;
            4'd3:    mid = HALF_E;
            4'd4:    mid = HALF_F;
            4'd5:    mid = HALF_G;
            4'd6:    mid = HALF_A;
            4'd7:    mid = HALF_B;
            default: mid = HALF_C;
        endcase
        case (code[5:4])
            2'd0:    h = mid << 1;
            2'd2:    h = mid >> 1;
            default: h = mid;
        endcase
        return h;
    endfunction

    logic [7:0]    cand;
    logic [CW-1:0] cnt;
    logic [0:0]    state;
    logic [PW-1:0] phase;
    logic [PW-1:0] halfReg;

    logic [7:0]    norm;
    logic [7:0]    nextCand;
    logic [CW-1:0] nextCnt;
    logic          accept;

    always_comb begin
        norm     = isValid(iNote) ? iNote : 8'h00;
        nextCand = norm;
        nextCnt  = {{(CW-1){1'b0}}, 1'b1};
        if (norm == cand) begin
            nextCand = cand;
            nextCnt  = (cnt == SAT) ? cnt : cnt + 1'b1;
        end
        accept = (nextCnt == SAT) && (nextCand != oNote);
    end

    assign oPlaying = (state == PLAY);

    // Acceptance always restarts the phase so a new note begins low.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            cand    <= 8'h00;
            cnt     <= '0;
            oNote   <= 8'h00;
            state   <= IDLE;
            phase   <= '0;
            halfReg <= '0;
            oAudio  <= 1'b0;
        end else begin
            cand <= nextCand;
            cnt  <= nextCnt;
            if (accept) begin
                oNote   <= nextCand;
                phase   <= '0;
                oAudio  <= 1'b0;
                halfReg <= halfOf(nextCand[5:0]);
                state   <= (nextCand != 8'h00) ? PLAY : IDLE;
            end else if (state == PLAY) begin
                if (phase == halfReg - 1'b1) begin
                    phase  <= '0;
                    oAudio <= ~oAudio;
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator at CLK_HZ=1 MHz, STABLE_CYCLES=4.
module tb_tone_generator;

    logic       iClk = 1'b0;
    logic       iReset;
    logic [7:0] iNote;
    logic       oAudio;
    logic       oPlaying;
    logic [7:0] oNote;

    int total = 0;
    int bad   = 0;
    int n;

    tone_generator #(
        .CLK_HZ       (1_000_000),
        .STABLE_CYCLES(4)
    ) dut (
        .iClk    (iClk),
        .iReset  (iReset),
        .iNote   (iNote),
        .oAudio  (oAudio),
        .oPlaying(oPlaying),
        .oNote   (oNote)
    );

    always #5 iClk = ~iClk;

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edges until oAudio changes level, capped so a stuck output cannot hang.
    task automatic measure(output int cnt);
        logic start;
        start = oAudio;
        cnt = 0;
        while (oAudio === start && cnt < 5000) begin
            tick(1);
            cnt++;
        end
    endtask

    task automatic playNote(input logic [7:0] code);
        iNote = code;
        tick(4);
    endtask

    initial begin
        iReset = 1'b1;
        iNote  = 8'h00;
        tick(2);
        check("reset_audio", int'(oAudio), 0);
        check("reset_playing", int'(oPlaying), 0);
        check("reset_note", int'(oNote), 0);
        iReset = 1'b0;

        // Mid A: accepted on the 4th edge, half-period 1136
        iNote = 8'h16;
        tick(3);
        check("a_before_accept", int'(oNote), 8'h00);
        check("a_playing_before", int'(oPlaying), 0);
        tick(1);
        check("a_accept_note", int'(oNote), 8'h16);
        check("a_accept_playing", int'(oPlaying), 1);
        check("a_accept_audio", int'(oAudio), 0);
        measure(n);
        check("a_first_rise", n, 1136);
        check("a_high", int'(oAudio), 1);
        measure(n);
        check("a_second_toggle", n, 1136);

        // Octave scaling and mid C
        playNote(8'h06);
        check("low_a_note", int'(oNote), 8'h06);
        measure(n);
        check("low_a_half", n, 2272);
        playNote(8'h26);
        check("high_a_note", int'(oNote), 8'h26);
        measure(n);
        check("high_a_half", n, 568);
        measure(n);
        check("high_a_half2", n, 568);
        playNote(8'h11);
        check("mid_c_note", int'(oNote), 8'h11);
        measure(n);
        check("mid_c_half", n, 1908);

        // Glitch of 3 samples must not disturb the waveform
        playNote(8'h16);
        measure(n);
        check("g_first_rise", n, 1136);
        tick(100);
        iNote = 8'h13;
        tick(3);
        check("g_note_held", int'(oNote), 8'h16);
        iNote = 8'h16;
        measure(n);
        check("g_toggle_spacing", n, 1033);
        check("g_note_after", int'(oNote), 8'h16);
        measure(n);
        check("g_next_toggle", n, 1136);

        // Change while high: audio drops at acceptance
        tick(10);
        check("c_high_before", int'(oAudio), 1);
        iNote = 8'h26;
        tick(3);
        check("c_old_note", int'(oNote), 8'h16);
        tick(1);
        check("c_new_note", int'(oNote), 8'h26);
        check("c_audio_low", int'(oAudio), 0);
        check("c_playing", int'(oPlaying), 1);
        measure(n);
        check("c_rise", n, 568);
        playNote(8'h00);
        check("s_playing", int'(oPlaying), 0);
        check("s_audio", int'(oAudio), 0);
        check("s_note", int'(oNote), 0);
        tick(600);
        check("s_audio_later", int'(oAudio), 0);

        // Invalid codes are silence
        playNote(8'h16);
        check("i1_play", int'(oPlaying), 1);
        iNote = 8'h18;
        tick(10);
        check("i1_note", int'(oNote), 0);
        check("i1_playing", int'(oPlaying), 0);
        check("i1_audio", int'(oAudio), 0);
        playNote(8'h16);
        check("i2_play", int'(oPlaying), 1);
        iNote = 8'h36;
        tick(10);
        check("i2_note", int'(oNote), 0);
        check("i2_playing", int'(oPlaying), 0);
        check("i2_audio", int'(oAudio), 0);
        playNote(8'h16);
        check("i3_play", int'(oPlaying), 1);
        iNote = 8'h41;
        tick(10);
        check("i3_note", int'(oNote), 0);
        check("i3_playing", int'(oPlaying), 0);
        check("i3_audio", int'(oAudio), 0);

        // Async reset mid high phase
        playNote(8'h16);
        measure(n);
        check("r_rise", n, 1136);
        tick(10);
        check("r_high", int'(oAudio), 1);
        #2;
        iReset = 1'b1;
        #1;
        check("r_async_audio", int'(oAudio), 0);
        check("r_async_playing", int'(oPlaying), 0);
        check("r_async_note", int'(oNote), 0);
        #3;
        iReset = 1'b0;
        tick(3);
        check("r_refilter", int'(oNote), 0);
        tick(1);
        check("r_reaccept", int'(oNote), 8'h16);
        check("r_replaying", int'(oPlaying), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tone_generator.md
# tone_generator

Downstream stage of the piano's source selector. Consumes the registered 8-bit note code the selector emits and produces a 1-bit square-wave audio signal at the pitch of that note. Input filtering holds out short glitches on the note code; a phase counter generates the waveform; silent or invalid codes mute the output.

## Interface
- CLK_HZ, 100_000_000: system clock frequency in Hz; all half-period constants are derived from it at elaboration.
- STABLE_CYCLES, 4: consecutive identical samples of iNote required before the code is accepted (≥1).
- iClk  in  1  system clock; all logic on rising edge.
- iReset  in  1  reset, asynchronous, active-high; one clock, no other clock domains.
- iNote  in  8  note code from selector; bits[3:0] degree 1..7 (C,D,E,F,G,A,B), bits[5:4] octave (0 low, 1 mid, 2 high), bits[7:6] zero.
- oAudio  out  1  square-wave audio output.
- oPlaying  out  1  high while a valid note is sounding.
- oNote  out  8  currently accepted note code (0 when silent).

## Operation
- Code validity: valid iff bits[7:6]==0, degree in 1..7, octave in 0..2. Any other value, including 0x00, is "silence" and is treated as code 0x00.
- Input filter: iNote is normalised (invalid→0x00) and compared to a candidate register each edge. On mismatch: candidate←new code, stability count←1. On match: count increments, saturating at STABLE_CYCLES.
- Acceptance: on the edge where the count reaches STABLE_CYCLES and candidate ≠ oNote, oNote←candidate. Re-asserting the already-accepted code never restarts the waveform.
- Half-period: mid-octave HALF = CLK_HZ/(2·f), integer truncation, f = 262, 294, 330, 349, 392, 440, 494 Hz for degrees 1..7. Low octave = 2·HALF_mid. High octave = HALF_mid>>1. The phase counter width is sized for the largest value (low C).
- State machine, two states:
  - IDLE: oAudio=0, oPlaying=0.
  - PLAY: oPlaying=1.
- Transitions:
  - IDLE→PLAY on acceptance of a valid code.
  - PLAY→IDLE on acceptance of 0x00.
  - PLAY→PLAY on acceptance of a different valid code.
- On every acceptance edge, the phase counter←0 and oAudio←0.
- In PLAY, the phase counter counts 0..HALF−1. On the edge where counter==HALF−1, counter←0 and oAudio toggles.
- Reset (any time, including mid-note): asynchronously forces oAudio=0, oPlaying=0, oNote=0x00, candidate=0x00, count=0, phase=0, state IDLE.

## Timing
- Acceptance latency: a code first sampled at edge k, held stable, is accepted at edge k+STABLE_CYCLES−1. oNote and oPlaying update at that edge.
- Glitch rejection: a code held for fewer than STABLE_CYCLES samples is never accepted.
- First oAudio rise: HALF edges after the acceptance edge. Thereafter the waveform has period 2·HALF cycles and 50% duty.
- Note change mid-period: the old phase is discarded at the acceptance edge, and oAudio goes low on that edge even if it was high.
- Silence: oAudio is low from the acceptance edge of 0x00 onward.
- Outputs are registered; there are no combinational paths from iNote to any output.

## Test plan
All scenarios use CLK_HZ=1_000_000 and STABLE_CYCLES=4.
- Reset then iNote=0x16 (mid A) held: oNote=0x16 and oPlaying=1 on the 4th sampling edge. oAudio rises 1136 cycles later, then toggles every 1136 cycles.
- Octave scaling: 0x06 gives a 2272-cycle half-period; 0x26 gives 568; 0x11 (mid C) gives 1908.
- Glitch: while playing 0x16, drive 0x13 for 3 cycles and then return to 0x16. oNote stays 0x16 and the oAudio toggle spacing is undisturbed.
- Note change and silence:
  - Playing 0x16, switch to 0x26: at acceptance oAudio=0, and the next rise comes 568 cycles later.
  - Then drive 0x00: oPlaying=0 and oAudio=0 after 4 edges.
- Invalid codes 0x18, 0x36 and 0x41, each held 10 cycles from PLAY: each is accepted as silence, giving oNote=0x00, oPlaying=0 and oAudio=0.
- Assert iReset asynchronously mid-high-phase of 0x16: all outputs are 0 immediately without waiting for a clock edge. After release, 0x16 requires the full 4-sample filter again.
